multiword_add_seq: RTL and testbench

- Sequencer that adds two N*W-bit operands by time-sharing one W-bit ripple_carry_adder over N chunk steps.
- Carry propagates between chunks through a register, so a narrow adder serves wide operands (e.g. generation and cell counters in the game-of-life datapath).
- Valid/ready handshake on input and output.
- Each chunk is held for SETTLE cycles so the worst-case ripple delay is met.

---
 rtl/multiword_add_seq_pkg.sv | 15 +
 rtl/ripple_carry_adder.sv | 27 ++
 rtl/multiword_add_seq.sv | 123 ++++++++++++
 tb/tb_multiword_add_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the chunked multi-word adder: state encoding and
// default geometry.
package multiword_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W      = 4;
    localparam int DEF_N      = 4;
    localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain W-bit ripple-carry adder; purely combinational, carry chains bit by bit
// from ci to co.
module ripple_carry_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic c;

    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two N*W-bit operands by feeding one W-bit ripple adder a chunk at a
// time, least significant first, with the carry held in a register between chunks.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int N      = DEF_N,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    input  logic           ci,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] sum,
    output logic           co,
    output logic           busy
);

    localparam int NW = N * W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(SETTLE) + 1;

    state_t        state;
    logic [NW-1:0] op_a;
    logic [NW-1:0] op_b;
    logic [NW-1:0] res;
    logic          carry;
    logic [CW-1:0] chunk;
    logic [SW-1:0] settle;

    logic [W-1:0]  add_s;
    logic          add_co;
    logic [NW-1:0] next_res;
    logic          capture;
    logic          last;

    // Adder sees registers only, so its inputs are stable for the whole settle window.
    ripple_carry_adder #(.W(W)) u_adder (
        .a  (op_a[W-1:0]),
        .b  (op_b[W-1:0]),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        capture  = (settle == SW'(SETTLE - 1));
        last     = (chunk == CW'(N - 1));
        next_res = (res >> W) | (NW'(add_s) << (NW - W));
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            chunk     <= '0;
            settle    <= '0;
            sum       <= '0;
            co        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= a;
                        op_b     <= b;
                        carry    <= ci;
                        chunk    <= '0;
                        settle   <= '0;
                        state    <= ADD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ADD: begin
                    if (capture) begin
                        res    <= next_res;
                        carry  <= add_co;
                        op_a   <= op_a >> W;
                        op_b   <= op_b >> W;
                        settle <= '0;
                        chunk  <= chunk + 1'b1;
                        if (last) begin
                            sum       <= next_res;
                            co        <= add_co;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq: a 4x4 instance with SETTLE=1, one with
// SETTLE=3, and an exhaustively swept 2x2 instance.
module tb_multiword_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance 0: W=4, N=4, SETTLE=1
    logic        rst0, iv0, ir0, ov0, or0, ci0, co0, busy0;
    logic [15:0] a0, b0, s0;
    // Instance 1: W=4, N=4, SETTLE=3
    logic        rst1, iv1, ir1, ov1, or1, ci1, co1, busy1;
    logic [15:0] a1, b1, s1;
    // Instance 2: W=2, N=2, SETTLE=1
    logic        rst2, iv2, ir2, ov2, or2, ci2, co2, busy2;
    logic [3:0]  a2, b2, s2;

    multiword_add_seq #(.W(4), .N(4), .SETTLE(1)) dut0 (
        .clk(clk), .reset(rst0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .ci(ci0), .out_valid(ov0), .out_ready(or0), .sum(s0), .co(co0), .busy(busy0)
    );
    multiword_add_seq #(.W(4), .N(4), .SETTLE(3)) dut1 (
        .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .ci(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1), .co(co1), .busy(busy1)
    );
    multiword_add_seq #(.W(2), .N(2), .SETTLE(1)) dut2 (
        .clk(clk), .reset(rst2), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .ci(ci2), .out_valid(ov2), .out_ready(or2), .sum(s2), .co(co2), .busy(busy2)
    );

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] sum;
        logic        co;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on instance 0, out_ready held low until the result shows.
    task automatic run0(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] es, input logic ec);
        int lat;
        check({name, " in_ready before accept"}, 32'(ir0), 32'd1);
        a0 = a; b0 = b; ci0 = ci; iv0 = 1'b1; or0 = 1'b0;
        @(posedge clk); #1;
        iv0 = 1'b0;
        check({name, " busy in ADD"}, 32'(busy0), 32'd1);
        lat = 0;
        while (!ov0 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " sum"}, 32'(s0), 32'(es));
        check({name, " co"}, 32'(co0), 32'(ec));
        or0 = 1'b1;
        @(posedge clk); #1;
        or0 = 1'b0;
        check({name, " in_ready after take"}, 32'(ir0), 32'd1);
        check({name, " out_valid after take"}, 32'(ov0), 32'd0);
    endtask

    initial begin
        int lat;
        logic [4:0] exp5;

        vecs[0] = '{"basic",     16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{"ripple",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{"ci_in",     16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{"byte_cy",   16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[4] = '{"msb_cy",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{"mixed",     16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vecs[6] = '{"max",       16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

        {iv0, or0, ci0, iv1, or1, ci1, iv2, or2, ci2} = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        check("reset in_ready", 32'(ir0), 32'd1);
        check("reset out_valid", 32'(ov0), 32'd0);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset sum", 32'(s0), 32'd0);
        check("reset co", 32'(co0), 32'd0);

        for (int i = 0; i < 7; i++)
            run0(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sum, vecs[i].co);

        // Back-pressure: result must hold and new operands must be refused.
        a0 = 16'h0F0F; b0 = 16'h0101; ci0 = 1'b0; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd4);
        a0 = 16'hFFFF; b0 = 16'hFFFF; ci0 = 1'b1; iv0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp out_valid held", 32'(ov0), 32'd1);
            check("bp sum held", 32'(s0), 32'h1010);
            check("bp co held", 32'(co0), 32'd0);
            check("bp in_ready low", 32'(ir0), 32'd0);
        end
        iv0 = 1'b0; or0 = 1'b1;
        @(posedge clk); #1;
        or0 = 1'b0;
        check("bp in_ready after take", 32'(ir0), 32'd1);
        check("bp busy after take", 32'(busy0), 32'd0);
        check("bp sum kept", 32'(s0), 32'h1010);

        // Reset in the middle of ADD abandons the operation.
        a0 = 16'hFFFF; b0 = 16'h0001; ci0 = 1'b0; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        check("midreset out_valid", 32'(ov0), 32'd0);
        check("midreset sum", 32'(s0), 32'd0);
        check("midreset co", 32'(co0), 32'd0);
        check("midreset in_ready", 32'(ir0), 32'd1);
        check("midreset busy", 32'(busy0), 32'd0);
        run0("3p4", 16'd3, 16'd4, 1'b0, 16'd7, 1'b0);

        // SETTLE=3: twelve-cycle latency, in_valid pulses during ADD ignored.
        a1 = 16'h00FF; b1 = 16'h0001; ci1 = 1'b0; iv1 = 1'b1; or1 = 1'b0;
        check("s3 in_ready before accept", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        a1 = 16'hFFFF; b1 = 16'hFFFF; ci1 = 1'b1;
        lat = 0;
        while (!ov1 && lat < 200) begin
            iv1 = lat[0];
            @(posedge clk); #1;
            lat++;
            if (!ov1) check("s3 in_ready in ADD", 32'(ir1), 32'd0);
        end
        iv1 = 1'b0;
        check("s3 latency", 32'(lat), 32'd12);
        check("s3 sum", 32'(s1), 32'h0100);
        check("s3 co", 32'(co1), 32'd0);
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        check("s3 in_ready after take", 32'(ir1), 32'd1);

        // Exhaustive sweep of the 2x2 instance.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int c = 0; c < 2; c++) begin
                    a2 = 4'(ai); b2 = 4'(bi); ci2 = 1'(c); iv2 = 1'b1;
                    @(posedge clk); #1;
                    iv2 = 1'b0;
                    lat = 0;
                    while (!ov2 && lat < 20) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    exp5 = 5'(ai + bi + c);
                    check($sformatf("exh lat a=%0d b=%0d ci=%0d", ai, bi, c), 32'(lat), 32'd2);
                    check($sformatf("exh a=%0d b=%0d ci=%0d", ai, bi, c), 32'({co2, s2}), 32'(exp5));
                    or2 = 1'b1;
                    @(posedge clk); #1;
                    or2 = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
